console_uart_tx: RTL and testbench
==================================

CONSOLE_UART_TX -- requirements
Module: console_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, byte FIFO entries (power of two, >= 2).
REQ-003 SHALL have parameter CONSOLE_ADDR, default 32'h0002_FFF8, character-output word address.
REQ-004 SHALL have parameter HALT_ADDR, default 32'h0002_FFFC, halt-request word address.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  data-memory request valid.
REQ-008 SHALL have port req_addr  input  32  data-memory request word address.
REQ-009 SHALL have port req_do_write  input  4  byte write enables; any nonzero bit means write.
REQ-010 SHALL have port req_data  input  32  write data; only bits [7:0] used.
REQ-011 SHALL have port uart_tx  output  1  serial line, 8N1, idle high.
REQ-012 SHALL have port tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-013 SHALL have port halt  output  1  sticky: all console output flushed after a halt request.
REQ-014 SHALL have port drop_count  output  8  saturating count of bytes dropped on FIFO overflow.

Function
REQ-015 SHALL decode a push when req_valid=1, req_addr==CONSOLE_ADDR and req_do_write!=0; pushed byte = req_data[7:0].
REQ-016 SHALL decode a halt request when req_valid=1, req_addr==HALT_ADDR and req_do_write!=0; reads (req_do_write==0) to either address SHALL be ignored.
REQ-017 SHALL write a pushed byte into the FIFO at the clock edge where the push is decoded; the FIFO becomes non-empty in the next cycle.
REQ-018 SHALL keep FIFO order strictly first-in first-out; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-019 SHALL, when the FIFO is full and a push arrives with no pop in the same cycle, discard the byte, leave FIFO contents unchanged and increment drop_count, saturating at 8'hFF.
REQ-020 SHALL, when the FIFO is full and a push and a pop coincide, accept the push (occupancy unchanged, no drop).
REQ-021 SHALL implement transmitter states IDLE, START, DATA, STOP.
REQ-022 SHALL, in IDLE with FIFO non-empty, pop the head byte into a shift register and enter START at that edge; uart_tx goes low in the following cycle (one cycle after the push edge for an empty FIFO).
REQ-023 SHALL hold each of START (0), 8 DATA bits (LSB first) and STOP (1) for exactly CLKS_PER_BIT cycles; a frame lasts 10*CLKS_PER_BIT cycles.
REQ-024 SHALL, at the end of STOP, pop the next byte and enter START directly if the FIFO is non-empty (back-to-back frames, no idle gap), else return to IDLE.
REQ-025 SHALL drive uart_tx high in IDLE and STOP, and registered (glitch-free) in all states.
REQ-026 SHALL latch a halt request into a sticky halt_pending flag; repeated requests have no further effect.
REQ-027 SHALL assert halt (registered) in the cycle after halt_pending=1, FIFO empty and state IDLE are all true; halt then stays 1 until reset.
REQ-028 SHALL, on a push and a halt request in the same cycle (impossible on one bus but must be tolerated), perform both; halt waits for that byte to transmit.
REQ-029 SHALL continue accepting and transmitting pushes after halt is asserted; halt does not deassert.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, set state=IDLE, FIFO empty, pointers 0, uart_tx=1, tx_busy=0, halt=0, halt_pending=0, drop_count=0; pushes and halt requests in that cycle are ignored.
REQ-031 SHALL abort any frame in progress on reset mid-frame; uart_tx returns high in the cycle after the reset edge.

Verification
REQ-032 SHALL cover: single write 8'h41 to 0x0002_FFF8, CLKS_PER_BIT=4 -> uart_tx low one cycle after push edge, bits 1,0,0,0,0,0,1,0 each 4 cycles, stop high, frame 40 cycles.
REQ-033 SHALL cover: 3 writes "abc" on consecutive cycles -> three back-to-back frames, 120 cycles total, no idle gap, correct order.
REQ-034 SHALL cover: 12 writes on consecutive cycles, FIFO_DEPTH=8 -> first 9 bytes transmitted (one popped immediately), drop_count=3.
REQ-035 SHALL cover: write 'x' then write to 0x0002_FFFC next cycle -> halt=0 until 'x' stop bit ends, halt=1 one cycle after return to IDLE, stays 1.
REQ-036 SHALL cover: reset asserted during DATA bit 3 -> uart_tx=1, tx_busy=0, drop_count=0 next cycle; read (do_write=0) to 0x0002_FFF8 -> no frame.

Source files
------------

// File: rtl/console_uart_tx.sv
// rtl/console_uart_tx.sv - memory-mapped console byte FIFO feeding an 8N1 UART transmitter, with sticky halt flag
module console_uart_tx #(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0002_FFF8,
    parameter logic [31:0] HALT_ADDR    = 32'h0002_FFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_do_write,
    input  logic [31:0] req_data,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        halt,
    output logic [7:0]  drop_count
);
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             uart_tx_next;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             halt_pending;

    logic push, halt_req, pop, push_ok, bit_end, fifo_empty;
    logic unused_data;

    // Only the low byte is a character; the upper bits are deliberately ignored.
    assign unused_data = ^req_data[31:8];

    assign push       = req_valid && (req_addr == CONSOLE_ADDR) && (req_do_write != 4'b0000);
    assign halt_req   = req_valid && (req_addr == HALT_ADDR) && (req_do_write != 4'b0000);
    assign fifo_empty = (fifo_count == '0);
    assign bit_end    = (clk_cnt == CNT_LAST);
    // Pop when idle, or at the last STOP cycle so the next frame follows with no gap.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
    assign push_ok    = push && ((fifo_count != FIFO_FULL) || pop);
    assign tx_busy    = (state != IDLE) || !fifo_empty;

    // FIFO storage: contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= req_data[7:0];
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= 8'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !push_ok && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Transmitter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // Transmitter next-state: each of START, 8 DATA bits and STOP lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                    shift_next   = fifo_mem[rd_ptr];
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    clk_cnt_next = '0;
                    bit_idx_next = 3'd0;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    if (pop) begin
                        state_next = START;
                        shift_next = fifo_mem[rd_ptr];
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level for the upcoming cycle, derived from where the FSM is heading.
    always_comb begin
        uart_tx_next = 1'b1;
        case (state_next)
            START:   uart_tx_next = 1'b0;
            DATA:    uart_tx_next = shift_next[0];
            default: uart_tx_next = 1'b1;
        endcase
    end

    // Registered serial output keeps the line glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= uart_tx_next;
        end
    end

    // Halt: latch the request, then assert once all console output has drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_pending <= 1'b0;
            halt         <= 1'b0;
        end else begin
            if (halt_req) begin
                halt_pending <= 1'b1;
            end
            if (halt_pending && fifo_empty && (state == IDLE)) begin
                halt <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_console_uart_tx.sv
// tb/tb_console_uart_tx.sv - self-checking bench for console_uart_tx
module tb_console_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] CON   = 32'h0002_FFF8;
    localparam logic [31:0] HLT   = 32'h0002_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [3:0]  req_do_write = 4'd0;
    logic [31:0] req_data = 32'd0;
    wire         uart_tx, tx_busy, halt;
    wire  [7:0]  drop_count;

    console_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH),
        .CONSOLE_ADDR(CON),
        .HALT_ADDR(HLT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_do_write(req_do_write),
        .req_data(req_data),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy),
        .halt(halt),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model: every accepted byte with its push edge and the edge its frame starts.
    int         q_push[$];
    int         q_pop[$];
    logic [7:0] q_byte[$];
    int         last_pop = -1000;
    logic       m_pend = 1'b0;
    logic       m_halt = 1'b0;
    logic       m_busy = 1'b0;
    int         m_drop = 0;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
        logic        exp_busy;
        logic        exp_halt;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic model_tx(input int e);
        int k;
        logic [7:0] b;
        for (int i = 0; i < q_pop.size(); i++) begin
            if (q_pop[i] <= e && e < q_pop[i] + FRAME) begin
                k = (e - q_pop[i]) / CPB;
                b = q_byte[i];
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b[k-1];
            end
        end
        return 1'b1;
    endfunction

    task automatic tick();
        logic prev_pend, prev_busy, push, hreq, pop_now;
        int cnt, p;
        prev_pend = m_pend;
        prev_busy = m_busy;
        push = req_valid && (req_addr == CON) && (req_do_write != 0);
        hreq = req_valid && (req_addr == HLT) && (req_do_write != 0);
        @(posedge clk);
        cyc++;
        if (reset) begin
            q_push.delete();
            q_pop.delete();
            q_byte.delete();
            last_pop = -1000;
            m_pend = 1'b0;
            m_halt = 1'b0;
            m_drop = 0;
        end else begin
            m_halt = m_halt | (prev_pend & ~prev_busy);
            if (hreq) m_pend = 1'b1;
            if (push) begin
                cnt = 0;
                pop_now = 1'b0;
                foreach (q_pop[i]) begin
                    if (q_push[i] < cyc && q_pop[i] >= cyc) cnt++;
                    if (q_pop[i] == cyc) pop_now = 1'b1;
                end
                if (cnt < DEPTH || pop_now) begin
                    p = (cyc + 1 > last_pop + FRAME) ? cyc + 1 : last_pop + FRAME;
                    q_push.push_back(cyc);
                    q_pop.push_back(p);
                    q_byte.push_back(req_data[7:0]);
                    last_pop = p;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            while (q_pop.size() > 0 && q_pop[0] + FRAME < cyc) begin
                void'(q_push.pop_front());
                void'(q_pop.pop_front());
                void'(q_byte.pop_front());
            end
        end
        m_busy = 1'b0;
        foreach (q_pop[i]) if (q_push[i] <= cyc && cyc < q_pop[i] + FRAME) m_busy = 1'b1;
        #1;
        check("model uart_tx", uart_tx, model_tx(cyc));
        check("model tx_busy", tx_busy, m_busy);
        check("model halt", halt, m_halt);
        check("model drop_count", drop_count, m_drop);
    endtask

    task automatic bus(input logic v, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        req_valid = v;
        req_addr = a;
        req_do_write = w;
        req_data = d;
        tick();
        req_valid = 1'b0;
        req_do_write = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output int n);
        n = 0;
        while (tx_busy && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_idle timeout", tx_busy, 1'b0);
    endtask

    initial begin
        int n, start;
        logic [9:0] frame;
        logic [31:0] a;

        vecs[0] = '{1'b1, CON,          4'b0001, 32'h0000_0041, 1'b1, 1'b0};
        vecs[1] = '{1'b1, CON,          4'b0000, 32'h0000_0041, 1'b0, 1'b0};
        vecs[2] = '{1'b0, CON,          4'b1111, 32'h0000_0042, 1'b0, 1'b0};
        vecs[3] = '{1'b1, CON - 32'd4,  4'b1111, 32'h0000_0043, 1'b0, 1'b0};
        vecs[4] = '{1'b1, HLT,          4'b1000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, HLT,          4'b0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, CON,          4'b0100, 32'hFFFF_FF5A, 1'b1, 1'b0};
        vecs[7] = '{1'b0, HLT,          4'b1111, 32'h0000_0000, 1'b0, 1'b0};

        do_reset();
        check("reset uart_tx", uart_tx, 1'b1);
        check("reset tx_busy", tx_busy, 1'b0);
        check("reset halt", halt, 1'b0);
        check("reset drop_count", drop_count, 8'd0);

        // Address/write-enable decode table.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            bus(vecs[i].v, vecs[i].a, vecs[i].w, vecs[i].d);
            check("vec busy", tx_busy, vecs[i].exp_busy);
            tick();
            check("vec halt", halt, vecs[i].exp_halt);
            idle(FRAME + 2);
        end

        // Single 'A' frame against a fixed bit pattern.
        do_reset();
        bus(1'b1, CON, 4'hF, 32'h41);
        check("frame41 idle before start", uart_tx, 1'b1);
        frame = {1'b1, 8'h41, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                tick();
                check("frame41 bit", uart_tx, frame[b]);
            end
        end
        tick();
        check("frame41 done", tx_busy, 1'b0);

        // Back-to-back "abc".
        do_reset();
        start = cyc + 1;
        bus(1'b1, CON, 4'h1, 32'h61);
        bus(1'b1, CON, 4'h1, 32'h62);
        bus(1'b1, CON, 4'h1, 32'h63);
        wait_idle(400, n);
        check("abc duration", cyc - (start + 1), 3 * FRAME);

        // Overflow: 12 consecutive pushes into an 8-deep FIFO.
        do_reset();
        start = cyc + 1;
        for (int i = 0; i < 12; i++) bus(1'b1, CON, 4'h2, 32'h30 + i);
        check("overflow drop_count", drop_count, 8'd3);
        wait_idle(1000, n);
        check("overflow duration", cyc - (start + 1), 9 * FRAME);

        // Halt waits for the pending 'x' to finish.
        do_reset();
        bus(1'b1, CON, 4'h1, 32'h78);
        bus(1'b1, HLT, 4'h1, 32'h0);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            check("halt early", halt, 1'b0);
        end
        tick();
        check("halt asserted", halt, 1'b1);
        bus(1'b1, HLT, 4'h1, 32'h0);
        bus(1'b1, CON, 4'h1, 32'h79);
        idle(FRAME + 3);
        check("halt sticky", halt, 1'b1);

        // Reset in DATA bit 3 with drops recorded, then a read to the console.
        do_reset();
        for (int i = 0; i < 12; i++) bus(1'b1, CON, 4'h1, 32'hA0 + i);
        idle(7);
        check("pre-reset drop_count", drop_count, 8'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midframe reset uart_tx", uart_tx, 1'b1);
        check("midframe reset tx_busy", tx_busy, 1'b0);
        check("midframe reset drop_count", drop_count, 8'd0);
        bus(1'b1, CON, 4'h0, 32'h41);
        idle(FRAME + 5);
        check("read no frame", tx_busy, 1'b0);

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1;
                bus(1'b1, CON, 4'h1, $urandom);
                reset = 1'b0;
            end else begin
                case ($urandom_range(0, 15))
                    0:       a = HLT;
                    1:       a = $urandom;
                    2:       a = CON + 32'd4;
                    default: a = CON;
                endcase
                bus(($urandom_range(0, 2) != 0),
                    a,
                    ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    $urandom);
            end
        end
        wait_idle(20 * FRAME, n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
